mem_port_arbiter: RTL and testbench

- Shares the CPU's single memory port between the fetch stage (inst requester) and the memory stage (data requester).
- Allows one outstanding transaction at a time.
- Data requests win by default. An aging counter keeps a stalled fetch from starving.
- Sits between the IF/MEM stages and the memory/SRAM bridge. It serialises requests and routes each response back to the requester that issued it.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side request/response signals.
// The arbiter takes the slave modport; the environment driving it takes master.
interface mem_port_arbiter_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 64
);
  logic                 inst_req_valid;
  logic                 inst_req_ready;
  logic [ADDR_WD-1:0]   inst_addr;
  logic                 inst_resp_valid;
  logic [DATA_WD-1:0]   inst_rdata;

  logic                 data_req_valid;
  logic                 data_req_ready;
  logic [ADDR_WD-1:0]   data_addr;
  logic                 data_wen;
  logic [DATA_WD/8-1:0] data_wstrb;
  logic [DATA_WD-1:0]   data_wdata;
  logic                 data_resp_valid;
  logic [DATA_WD-1:0]   data_rdata;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ADDR_WD-1:0]   mem_addr;
  logic                 mem_wen;
  logic [DATA_WD/8-1:0] mem_wstrb;
  logic [DATA_WD-1:0]   mem_wdata;
  logic                 mem_resp_valid;
  logic [DATA_WD-1:0]   mem_rdata;

  logic                 busy;

  modport slave (
    input  inst_req_valid, inst_addr,
    input  data_req_valid, data_addr, data_wen, data_wstrb, data_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output inst_req_ready, inst_resp_valid, inst_rdata,
    output data_req_ready, data_resp_valid, data_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    output busy
  );

  modport master (
    output inst_req_valid, inst_addr,
    output data_req_valid, data_addr, data_wen, data_wstrb, data_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  inst_req_ready, inst_resp_valid, inst_rdata,
    input  data_req_ready, data_resp_valid, data_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction
// in flight; data wins by default, an aging counter prevents fetch starvation.
module mem_port_arbiter #(
  parameter int ADDR_WD  = 32,
  parameter int DATA_WD  = 64,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               resetn,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t               state, state_nxt;
  logic [3:0]           age_cnt;
  logic [ADDR_WD-1:0]   req_addr_r;
  logic                 req_wen_r;
  logic [DATA_WD/8-1:0] req_wstrb_r;
  logic [DATA_WD-1:0]   req_wdata_r;
  logic                 owner_r;     // 1 = inst, 0 = data
  logic                 grant_inst;
  logic                 grant_data;
  logic                 force_inst;
  logic                 resp_fire;

  assign force_inst = bus.inst_req_valid && (age_cnt >= 4'(MAX_WAIT));

  // Grants are gated by resetn so both readies read 0 while reset is held.
  always_comb begin
    state_nxt  = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    unique case (state)
      IDLE: begin
        if (resetn) begin
          if (force_inst || (bus.inst_req_valid && !bus.data_req_valid))
            grant_inst = 1'b1;
          else if (bus.data_req_valid)
            grant_data = 1'b1;
          if (grant_inst || grant_data)
            state_nxt = REQ;
        end
      end
      REQ:     if (bus.mem_req_ready)  state_nxt = WAIT;
      WAIT:    if (bus.mem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      age_cnt     <= '0;
      req_addr_r  <= '0;
      req_wen_r   <= 1'b0;
      req_wstrb_r <= '0;
      req_wdata_r <= '0;
      owner_r     <= 1'b0;
    end else begin
      if (grant_inst) begin
        age_cnt     <= '0;
        req_addr_r  <= bus.inst_addr;
        req_wen_r   <= 1'b0;
        req_wstrb_r <= '0;
        req_wdata_r <= '0;
        owner_r     <= 1'b1;
      end else if (grant_data) begin
        if (bus.inst_req_valid && age_cnt != 4'hF)
          age_cnt <= age_cnt + 4'd1;
        req_addr_r  <= bus.data_addr;
        req_wen_r   <= bus.data_wen;
        req_wstrb_r <= bus.data_wstrb;
        req_wdata_r <= bus.data_wdata;
        owner_r     <= 1'b0;
      end
    end
  end

  assign bus.inst_req_ready = grant_inst;
  assign bus.data_req_ready = grant_data;

  assign bus.mem_req_valid  = (state == REQ);
  assign bus.mem_addr       = req_addr_r;
  assign bus.mem_wen        = req_wen_r;
  assign bus.mem_wstrb      = req_wstrb_r;
  assign bus.mem_wdata      = req_wdata_r;

  // Responses outside WAIT are dropped; read data reaches only the owner.
  assign resp_fire          = (state == WAIT) && bus.mem_resp_valid;
  assign bus.inst_resp_valid = resp_fire && owner_r;
  assign bus.data_resp_valid = resp_fire && !owner_r;
  assign bus.inst_rdata      = bus.inst_resp_valid ? bus.mem_rdata : '0;
  assign bus.data_rdata      = bus.data_resp_valid ? bus.mem_rdata : '0;

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: requester and memory agents, a
// protocol-level reference model and a response scoreboard.
module tb_mem_port_arbiter;

  localparam int ADDR_WD  = 32;
  localparam int DATA_WD  = 64;
  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } txn_t;

  logic clk;
  logic resetn;

  mem_port_arbiter_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD)) bus ();

  mem_port_arbiter #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .MAX_WAIT(MAX_WAIT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus knobs
  int inst_pct = 0, data_pct = 0, inst_left = 0, data_left = 0;
  int rdy_mode = 0, dly_max = 0;
  bit dly_fix = 0, spur_en = 0, store_only = 0;

  logic [63:0] inst_q[$];
  logic [63:0] data_q[$];
  logic [63:0] ref_mem[logic [31:0]];
  logic [63:0] dev_mem[logic [31:0]];
  string       hist = "";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [31:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] st);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 + 32'($urandom_range(0, 7)) * 32'd8;
  endfunction

  function automatic bit outs_any();
    return |{bus.inst_req_ready, bus.data_req_ready, bus.inst_resp_valid, bus.data_resp_valid,
             bus.mem_req_valid, bus.busy, bus.mem_wen, bus.mem_addr, bus.mem_wstrb,
             bus.mem_wdata, bus.inst_rdata, bus.data_rdata};
  endfunction

  // inst requester: holds a request until it is accepted
  initial begin
    bit acc = 0;
    bus.inst_req_valid = 1'b0;
    bus.inst_addr      = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) bus.inst_req_valid = 1'b0;
      else if (!bus.inst_req_valid || acc) begin
        if (inst_left > 0 && $urandom_range(0, 99) < inst_pct) begin
          bus.inst_req_valid = 1'b1;
          bus.inst_addr      = rand_addr();
          inst_left--;
        end else bus.inst_req_valid = 1'b0;
      end
      @(negedge clk); #2;
      acc = bus.inst_req_valid && bus.inst_req_ready;
    end
  end

  // data requester
  initial begin
    bit acc = 0;
    bus.data_req_valid = 1'b0;
    bus.data_addr      = '0;
    bus.data_wen       = 1'b0;
    bus.data_wstrb     = '0;
    bus.data_wdata     = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) bus.data_req_valid = 1'b0;
      else if (!bus.data_req_valid || acc) begin
        if (data_left > 0 && $urandom_range(0, 99) < data_pct) begin
          bus.data_req_valid = 1'b1;
          bus.data_addr      = rand_addr();
          bus.data_wen       = store_only ? 1'b1 : 1'($urandom_range(0, 1));
          bus.data_wstrb     = 8'($urandom);
          bus.data_wdata     = {$urandom, $urandom};
          data_left--;
        end else bus.data_req_valid = 1'b0;
      end
      @(negedge clk); #2;
      acc = bus.data_req_valid && bus.data_req_ready;
    end
  end

  // memory device: random ready, delayed response, spurious pulses when idle
  initial begin
    bit          pend = 0;
    int          dly  = 0;
    logic [63:0] pdata = '0, old;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
      end else begin
        bus.mem_req_ready = (rdy_mode == 1) ? 1'b1 :
                            (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (pend && dly == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = pdata;
        end else begin
          bus.mem_resp_valid = spur_en && !pend && ($urandom_range(0, 5) == 0);
          bus.mem_rdata      = {$urandom, $urandom};
        end
      end
      @(negedge clk); #2;
      if (!resetn) pend = 0;
      else begin
        if (bus.mem_resp_valid) pend = 0;
        else if (pend && dly > 0) dly--;
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          pend = 1;
          dly  = dly_fix ? dly_max : $urandom_range(0, dly_max);
          old  = dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : init_word(bus.mem_addr);
          if (bus.mem_wen) begin
            pdata = merge(old, bus.mem_wdata, bus.mem_wstrb);
            dev_mem[bus.mem_addr] = pdata;
          end else pdata = old;
        end
      end
    end
  end

  // reference model: phase 0 free, 1 request issued, 2 awaiting response
  int   m_phase = 0;
  int   m_age   = 0;
  bit   m_owner_i = 0;
  txn_t m_txn;

  always @(negedge clk) begin
    bit          iv, dv, gi, gd;
    logic [63:0] old, rsp;
    if (!resetn) begin
      m_phase = 0;
      m_age   = 0;
      inst_q.delete();
      data_q.delete();
      check("reset_outputs", 64'(outs_any()), 64'd0);
    end else begin
      iv = bus.inst_req_valid;
      dv = bus.data_req_valid;
      gi = (m_phase == 0) && iv && (m_age >= MAX_WAIT || !dv);
      gd = (m_phase == 0) && dv && !gi;
      check("inst_req_ready", 64'(bus.inst_req_ready), 64'(gi));
      check("data_req_ready", 64'(bus.data_req_ready), 64'(gd));
      if (bus.inst_req_ready) hist = {hist, "I"};
      if (bus.data_req_ready) hist = {hist, "D"};
      check("busy", 64'(bus.busy), 64'(m_phase != 0));
      check("mem_req_valid", 64'(bus.mem_req_valid), 64'(m_phase == 1));
      if (m_phase == 1) begin
        check("mem_addr",  64'(bus.mem_addr),  64'(m_txn.addr));
        check("mem_wen",   64'(bus.mem_wen),   64'(m_txn.wen));
        check("mem_wstrb", 64'(bus.mem_wstrb), 64'(m_txn.wstrb));
        check("mem_wdata", bus.mem_wdata, m_txn.wdata);
      end
      check("inst_resp_valid", 64'(bus.inst_resp_valid),
            64'(m_phase == 2 && bus.mem_resp_valid && m_owner_i));
      check("data_resp_valid", 64'(bus.data_resp_valid),
            64'(m_phase == 2 && bus.mem_resp_valid && !m_owner_i));
      case (m_phase)
        0: if (gi || gd) begin
          m_owner_i = gi;
          if (gi) begin
            m_txn = '{addr: bus.inst_addr, wen: 1'b0, wstrb: 8'h00, wdata: 64'd0};
            m_age = 0;
          end else begin
            m_txn = '{addr: bus.data_addr, wen: bus.data_wen, wstrb: bus.data_wstrb,
                      wdata: bus.data_wdata};
            if (iv && m_age < 15) m_age++;
          end
          m_phase = 1;
        end
        1: if (bus.mem_req_ready) begin
          old = ref_mem.exists(m_txn.addr) ? ref_mem[m_txn.addr] : init_word(m_txn.addr);
          if (m_txn.wen) begin
            rsp = merge(old, m_txn.wdata, m_txn.wstrb);
            ref_mem[m_txn.addr] = rsp;
          end else rsp = old;
          if (m_owner_i) inst_q.push_back(rsp);
          else           data_q.push_back(rsp);
          m_phase = 2;
        end
        2: if (bus.mem_resp_valid) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // response monitor / scoreboard
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.inst_resp_valid) begin
        if (inst_q.size() == 0) check("inst_resp_unexpected", 64'd1, 64'd0);
        else check("inst_rdata", bus.inst_rdata, inst_q.pop_front());
      end else check("inst_rdata_quiet", bus.inst_rdata, 64'd0);
      if (bus.data_resp_valid) begin
        if (data_q.size() == 0) check("data_resp_unexpected", 64'd1, 64'd0);
        else check("data_rdata", bus.data_rdata, data_q.pop_front());
      end else check("data_rdata_quiet", bus.data_rdata, 64'd0);
    end
  end

  task automatic idle_wait(input int max_cycles);
    bit done = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk); #3;
      done = (inst_left == 0 && data_left == 0 && !bus.inst_req_valid &&
              !bus.data_req_valid && !bus.busy);
    end
    check("idle_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    bit found;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #3 resetn = 1'b1;

    // single fetch at minimum latency
    rdy_mode = 1; dly_max = 0; dly_fix = 1; spur_en = 0;
    inst_pct = 100; inst_left = 1;
    idle_wait(30);

    // simultaneous store and fetch: store first
    store_only = 1; data_pct = 100; inst_left = 1; data_left = 1;
    idle_wait(30);
    store_only = 0;

    // memory backpressure
    rdy_mode = 2; data_left = 1;
    repeat (8) @(negedge clk);
    #3 rdy_mode = 1;
    idle_wait(30);

    // spurious responses / readies while idle or requesting
    spur_en = 1; rdy_mode = 0; dly_fix = 0; dly_max = 3;
    inst_pct = 20; inst_left = 4; data_pct = 20; data_left = 4;
    idle_wait(300);
    spur_en = 0;

    // reset while an inst transaction waits for its response
    rdy_mode = 1; dly_max = 3; dly_fix = 1; inst_pct = 100; inst_left = 1;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk); #3;
      found = bus.busy && !bus.mem_req_valid && !bus.mem_resp_valid;
    end
    check("reach_wait", 64'(found), 64'd1);
    resetn = 1'b0;
    #1 check("reset_immediate", 64'(outs_any()), 64'd0);
    repeat (2) @(negedge clk);
    #3 resetn = 1'b1;
    dly_fix = 0; data_pct = 100; data_left = 1;
    idle_wait(30);

    // starvation: both requesters held valid
    hist = ""; rdy_mode = 0; dly_max = 2;
    inst_pct = 100; inst_left = 2; data_pct = 100; data_left = 8;
    for (int c = 0; c < 400 && hist.len() < 10; c++) @(negedge clk);
    n_checks++;
    if (hist != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL grant_order: got %s expected DDDDIDDDDI", hist);
    end
    idle_wait(50);

    // randomised traffic
    spur_en = 1;
    for (int blk = 0; blk < 6; blk++) begin
      inst_pct = $urandom_range(20, 90); data_pct = $urandom_range(20, 90);
      inst_left = 60; data_left = 60;
      rdy_mode = (blk == 5) ? 1 : 0; dly_max = $urandom_range(0, 3);
      idle_wait(3000);
    end
    spur_en = 0;
    repeat (10) @(negedge clk);
    check("scoreboard_empty", 64'(inst_q.size() + data_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
